peri_bus_arbiter: RTL

//  Owns the single peripheral-memory port. Merges two requesters: CPU stores (addr >= 0x100,

---
 rtl/peri_bus_arbiter_if.sv | 50 +++++
 rtl/peri_bus_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/peri_bus_arbiter_if.sv
// Purpose: bundles the CPU posted-store, vector-unit and peripheral-port signals of the arbiter.
// Ports: cpu_* (store strobe + stall), vec_* (req/gnt/read return), per_* (req/ack slave port), busy/err status.
// Modports: slave = arbiter side, master = requesters + peripheral environment side.
interface peri_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_web;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_stall;

    logic              vec_req;
    logic              vec_we;
    logic [ADDR_W-1:0] vec_addr;
    logic [DATA_W-1:0] vec_wdata;
    logic              vec_gnt;
    logic              vec_rvalid;
    logic [DATA_W-1:0] vec_rdata;

    logic              per_req;
    logic              per_we;
    logic [ADDR_W-1:0] per_addr;
    logic [DATA_W-1:0] per_wdata;
    logic              per_ack;
    logic [DATA_W-1:0] per_rdata;

    logic              busy;
    logic              err;

    modport slave (
        input  cpu_web, cpu_addr, cpu_data,
        output cpu_stall,
        input  vec_req, vec_we, vec_addr, vec_wdata,
        output vec_gnt, vec_rvalid, vec_rdata,
        output per_req, per_we, per_addr, per_wdata,
        input  per_ack, per_rdata,
        output busy, err
    );

    modport master (
        output cpu_web, cpu_addr, cpu_data,
        input  cpu_stall,
        output vec_req, vec_we, vec_addr, vec_wdata,
        input  vec_gnt, vec_rvalid, vec_rdata,
        input  per_req, per_we, per_addr, per_wdata,
        output per_ack, per_rdata,
        input  busy, err
    );
endinterface

// File: rtl/peri_bus_arbiter.sv
// Purpose: owns the peripheral port; posts CPU stores into a FIFO and round-robins them with vector-unit requests.
// Latency: request seen in IDLE -> per_req 1 cycle later; vec_gnt/vec_rvalid/err 1 cycle after ack/abort.
// Backpressure: cpu_stall while the store FIFO is full; vector unit holds vec_req until vec_gnt; slave stalls via per_ack.
// Ports: clk, rst (async active-high); bus_io (slave modport) carries cpu_*, vec_*, per_*, busy, err.
module peri_bus_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    peri_bus_arbiter_if.slave     bus_io
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUS_CPU = 2'd1,
        S_BUS_VEC = 2'd2
    } state_t;

    // Posted CPU store FIFO
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Arbiter / port state
    state_t            state_q;
    logic              last_vec_q;     // 1 = vector unit owned the port last
    logic [7:0]        wait_q;
    logic              per_req_q;
    logic              per_we_q;
    logic [ADDR_W-1:0] per_addr_q;
    logic [DATA_W-1:0] per_wdata_q;
    logic              vec_gnt_q;
    logic              vec_rvalid_q;
    logic [DATA_W-1:0] vec_rdata_q;
    logic              err_q;

    logic fifo_full, fifo_empty, enq, deq;
    logic bus_done, bus_tmo;
    logic cpu_pend, vec_pend, pick_vec;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // Full blocks enqueue even if the head retires this cycle: stall comes from registered count only.
    assign enq = !bus_io.cpu_web && !fifo_full;

    assign bus_done = per_req_q && bus_io.per_ack;
    assign bus_tmo  = per_req_q && !bus_io.per_ack && (wait_q == 8'(TIMEOUT - 1));
    assign deq      = (state_q == S_BUS_CPU) && (bus_done || bus_tmo);

    // The vector unit still holds vec_req in the cycle it sees vec_gnt; that is the
    // finished request, so it is not eligible for a fresh grant in that cycle.
    assign cpu_pend = !fifo_empty;
    assign vec_pend = bus_io.vec_req && !vec_gnt_q;
    assign pick_vec = vec_pend && (!cpu_pend || !last_vec_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
        if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr_q[wr_ptr_q] <= bus_io.cpu_addr;
            fifo_data_q[wr_ptr_q] <= bus_io.cpu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_vec_q   <= 1'b1;          // CPU wins the first tie
            wait_q       <= '0;
            per_req_q    <= 1'b0;
            per_we_q     <= 1'b0;
            per_addr_q   <= '0;
            per_wdata_q  <= '0;
            vec_gnt_q    <= 1'b0;
            vec_rvalid_q <= 1'b0;
            vec_rdata_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            vec_gnt_q    <= 1'b0;
            vec_rvalid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_pend || vec_pend) begin
                        per_req_q <= 1'b1;
                        wait_q    <= '0;
                        if (pick_vec) begin
                            state_q     <= S_BUS_VEC;
                            per_we_q    <= bus_io.vec_we;
                            per_addr_q  <= bus_io.vec_addr;
                            per_wdata_q <= bus_io.vec_wdata;
                        end else begin
                            state_q     <= S_BUS_CPU;
                            per_we_q    <= 1'b1;
                            per_addr_q  <= fifo_addr_q[rd_ptr_q];
                            per_wdata_q <= fifo_data_q[rd_ptr_q];
                        end
                    end
                end
                S_BUS_CPU, S_BUS_VEC: begin
                    if (bus_done || bus_tmo) begin
                        // Returning to IDLE guarantees one per_req=0 cycle between transactions.
                        per_req_q  <= 1'b0;
                        state_q    <= S_IDLE;
                        last_vec_q <= (state_q == S_BUS_VEC);
                        err_q      <= bus_tmo;
                        if (state_q == S_BUS_VEC) begin
                            vec_gnt_q <= 1'b1;
                            if (bus_done && !per_we_q) begin
                                vec_rvalid_q <= 1'b1;
                                vec_rdata_q  <= bus_io.per_rdata;
                            end
                        end
                    end else if (per_req_q) begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus_io.cpu_stall  = fifo_full;
    assign bus_io.vec_gnt    = vec_gnt_q;
    assign bus_io.vec_rvalid = vec_rvalid_q;
    assign bus_io.vec_rdata  = vec_rdata_q;
    assign bus_io.per_req    = per_req_q;
    assign bus_io.per_we     = per_we_q;
    assign bus_io.per_addr   = per_addr_q;
    assign bus_io.per_wdata  = per_wdata_q;
    assign bus_io.busy       = !fifo_empty || (state_q != S_IDLE);
    assign bus_io.err        = err_q;
endmodule
